ddr_tx_gearbox: RTL and testbench

Transmit-side gearbox that turns a stream of parallel words into one bit-pair per SCLK cycle, driving the D0/D1 inputs of an ODDRX1F output register. D0 is the bit sent first (rising-edge half), D1 the bit sent second (falling-edge half). It sits between a word-oriented source (FIFO or packetiser) and the ODDRX1F pad primitive, and also generates the pad output-enable for a bidirectional DDR bus.

---
 rtl/ddr_tx_gearbox.sv | 111 +++++++++++
 tb/tb_ddr_tx_gearbox.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ddr_tx_gearbox.sv
// Word-to-bit-pair gearbox feeding the D0/D1 inputs of an ODDRX1F.
// MSB-first: each word becomes WORD_WIDTH/2 consecutive pairs, back-to-back words are seamless.
module ddr_tx_gearbox #(
  parameter int   WORD_WIDTH = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                  SCLK,
  input  logic                  RST,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  D0,
  output logic                  D1,
  output logic                  oe,
  output logic                  busy,
  output logic                  burst_end
);

  localparam int N      = WORD_WIDTH / 2;
  localparam int BEAT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state, state_nxt;
  logic [BEAT_W-1:0]       beat, beat_nxt;
  logic [WORD_WIDTH-1:0]   sreg_p0, sreg_nxt;
  logic                    d0_p1, d1_p1, oe_p1;
  logic                    d0_nxt, d1_nxt, oe_nxt;
  logic                    rst_hold;
  logic                    load;

  // rst_hold keeps in_ready low for the cycle following any reset edge.
  always_ff @(posedge SCLK) begin
    if (RST) begin
      state    <= IDLE;
      beat     <= '0;
      sreg_p0  <= '0;
      d0_p1    <= IDLE_LEVEL;
      d1_p1    <= IDLE_LEVEL;
      oe_p1    <= 1'b0;
      rst_hold <= 1'b1;
    end else begin
      state    <= state_nxt;
      beat     <= beat_nxt;
      sreg_p0  <= sreg_nxt;
      d0_p1    <= d0_nxt;
      d1_p1    <= d1_nxt;
      oe_p1    <= oe_nxt;
      rst_hold <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    sreg_nxt  = sreg_p0;
    d0_nxt    = d0_p1;
    d1_nxt    = d1_p1;
    oe_nxt    = oe_p1;
    in_ready  = 1'b0;
    burst_end = 1'b0;
    load      = 1'b0;

    unique case (state)
      IDLE: begin
        in_ready = ~rst_hold;
        load     = ~rst_hold & in_valid;
      end
      SHIFT: begin
        if (beat == LAST_BEAT) begin
          in_ready = 1'b1;
          if (in_valid) begin
            load = 1'b1;
          end else begin
            burst_end = 1'b1;
            state_nxt = IDLE;
            beat_nxt  = '0;
            d0_nxt    = IDLE_LEVEL;
            d1_nxt    = IDLE_LEVEL;
            oe_nxt    = 1'b0;
          end
        end else begin
          // sreg_p0 still holds the current pair in its top two bits.
          sreg_nxt = sreg_p0 << 2;
          d0_nxt   = sreg_p0[WORD_WIDTH-3];
          d1_nxt   = sreg_p0[WORD_WIDTH-4];
          beat_nxt = beat + BEAT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (load) begin
      state_nxt = SHIFT;
      beat_nxt  = '0;
      sreg_nxt  = in_data;
      d0_nxt    = in_data[WORD_WIDTH-1];
      d1_nxt    = in_data[WORD_WIDTH-2];
      oe_nxt    = 1'b1;
    end
  end

  assign D0   = d0_p1;
  assign D1   = d1_p1;
  assign oe   = oe_p1;
  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_ddr_tx_gearbox.sv
// Bench for ddr_tx_gearbox: vector table, scoreboarded word stream, and a 4-bit/IDLE_LEVEL=0 instance.
module tb_ddr_tx_gearbox;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld, vld4;
  logic [7:0] data;
  logic [3:0] data4;
  logic       rdy, d0, d1, oe, busy, be;
  logic       rdy4, d04, d14, oe4, busy4, be4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ddr_tx_gearbox #(.WORD_WIDTH(8), .IDLE_LEVEL(1'b1)) dut8 (
    .SCLK(clk), .RST(rst), .in_data(data), .in_valid(vld), .in_ready(rdy),
    .D0(d0), .D1(d1), .oe(oe), .busy(busy), .burst_end(be)
  );

  ddr_tx_gearbox #(.WORD_WIDTH(4), .IDLE_LEVEL(1'b0)) dut4 (
    .SCLK(clk), .RST(rst), .in_data(data4), .in_valid(vld4), .in_ready(rdy4),
    .D0(d04), .D1(d14), .oe(oe4), .busy(busy4), .burst_end(be4)
  );

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] data;
    logic [5:0] exp;   // {D0, D1, oe, in_ready, busy, burst_end}
  } vec_t;

  vec_t       vecs[$];
  logic [1:0] sb[$];
  logic [7:0] words[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic [5:0] e);
    vecs.push_back('{r, v, d, e});
  endtask

  initial begin
    rst = 1'b1; vld = 1'b1; data = 8'hA5; vld4 = 1'b0; data4 = 4'h0;

    // reset held with in_valid high, then release
    add(1, 1, 8'hA5, 6'b110000);
    add(1, 1, 8'hA5, 6'b110000);
    add(0, 0, 8'h00, 6'b110000);
    add(0, 0, 8'h00, 6'b110100);
    // single word 0xA5
    add(0, 1, 8'hA5, 6'b110100);
    add(0, 0, 8'h00, 6'b101010);
    add(0, 0, 8'h00, 6'b101010);
    add(0, 0, 8'h00, 6'b011010);
    add(0, 0, 8'h00, 6'b011111);
    // back-to-back 0xA5, 0x3C
    add(0, 1, 8'hA5, 6'b110100);
    add(0, 1, 8'h3C, 6'b101010);
    add(0, 1, 8'h3C, 6'b101010);
    add(0, 1, 8'h3C, 6'b011010);
    add(0, 1, 8'h3C, 6'b011110);
    add(0, 1, 8'h3C, 6'b001010);
    add(0, 1, 8'h3C, 6'b111010);
    add(0, 1, 8'h3C, 6'b111010);
    add(0, 0, 8'h00, 6'b001111);
    // 0x96 with in_valid/in_data toggling mid-word
    add(0, 1, 8'h96, 6'b110100);
    add(0, 0, 8'h55, 6'b101010);
    add(0, 1, 8'h0F, 6'b011010);
    add(0, 1, 8'hF0, 6'b011010);
    add(0, 0, 8'h00, 6'b101111);
    add(0, 0, 8'h00, 6'b110100);
    // reset at beat 1 of 0xFF
    add(0, 1, 8'hFF, 6'b110100);
    add(0, 0, 8'h00, 6'b111010);
    add(1, 0, 8'h00, 6'b111010);
    add(0, 0, 8'h00, 6'b110000);
    add(0, 0, 8'h00, 6'b110100);
    add(0, 0, 8'h00, 6'b110100);

    @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; vld = vecs[i].vld; data = vecs[i].data;
      #1;
      chk($sformatf("vec%0d", i), {26'd0, d0, d1, oe, rdy, busy, be}, {26'd0, vecs[i].exp});
    end

    // sustained stream with in_valid held high; expected pairs queued on each handshake
    begin
      int idx  = 0;
      int cyc  = 0;
      int last = 0;
      logic [1:0] exp_pair;
      for (int i = 0; i < 6; i++) words[i] = 8'($urandom);
      while ((idx < 6 || sb.size() > 0) && cyc < 200) begin
        @(negedge clk);
        vld  = (idx < 6);
        data = (idx < 6) ? words[idx] : 8'h00;
        #1;
        if (oe) begin
          if (sb.size() == 0) begin
            chk("stream_extra_pair", {31'd0, oe}, 32'd0);
          end else begin
            exp_pair = sb.pop_front();
            chk("stream_pair", {30'd0, d0, d1}, {30'd0, exp_pair});
          end
        end else if (idx > 0 && sb.size() > 0) begin
          chk("stream_oe", {31'd0, oe}, 32'd1);
        end
        if (rdy && vld) begin
          for (int b = 3; b >= 0; b--) begin
            logic [7:0] w;
            w = words[idx];
            sb.push_back({w[2*b+1], w[2*b]});
          end
          if (idx > 0) chk("stream_gap", 32'(cyc - last), 32'd4);
          last = cyc;
          idx++;
        end
        cyc++;
      end
      if (idx < 6 || sb.size() > 0) chk("stream_timeout", 32'(sb.size()), 32'd0);
      @(negedge clk);
      vld = 1'b0;
      #1;
      chk("stream_idle", {29'd0, d0, d1, oe}, {29'd0, 3'b110});
    end

    // WORD_WIDTH=4, IDLE_LEVEL=0, word 0x9
    @(negedge clk);
    #1;
    chk("w4_idle", {28'd0, d04, d14, oe4, rdy4}, {28'd0, 4'b0001});
    vld4 = 1'b1; data4 = 4'h9;
    @(negedge clk);
    vld4 = 1'b0; data4 = 4'h0;
    #1;
    chk("w4_pair0", {27'd0, d04, d14, oe4, rdy4, be4}, {27'd0, 5'b10100});
    @(negedge clk);
    #1;
    chk("w4_pair1", {27'd0, d04, d14, oe4, rdy4, be4}, {27'd0, 5'b01111});
    @(negedge clk);
    #1;
    chk("w4_after", {27'd0, d04, d14, oe4, busy4, be4}, {27'd0, 5'b00000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
